// File: rtl/dmem_pkg.sv
// Shared constants and region decode for the data-memory responder.
package dmem_pkg;

    localparam logic [9:0] MMIO_BASE = 10'h3C0;

    // Word offsets within the MMIO window (DIR_DMEM[5:2])
    localparam logic [3:0] OFF_GPIO_OUT  = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN   = 4'h1;
    localparam logic [3:0] OFF_CYCLE     = 4'h2;
    localparam logic [3:0] OFF_TIMER_CMP = 4'h3;
    localparam logic [3:0] OFF_STATUS    = 4'h4;
    localparam logic [3:0] OFF_CTRL      = 4'h5;

    localparam int unsigned ST_MATCH    = 0;
    localparam int unsigned ST_MISALIGN = 1;
    localparam int unsigned ST_COLLIDE  = 2;
    localparam int unsigned STATUS_W    = 3;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    function automatic region_e decode_region(input logic [9:0] addr, input logic [8:0] ram_limit);
        if (addr >= MMIO_BASE) return REG_MMIO;
        if ({1'b0, addr[9:2]} < ram_limit) return REG_RAM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO register block: GPIO, cycle counter, compare timer, sticky STATUS, CTRL and IRQ.
module dmem_mmio #(
    parameter int unsigned GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              wr_en,
    input  logic [3:0]        offset,
    input  logic [31:0]       wdata,
    input  logic              set_misalign,
    input  logic              set_collide,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [31:0]       rdata,
    output logic              irq
);
    import dmem_pkg::*;

    logic [GPIO_W-1:0]   gpio_out_q;
    logic [GPIO_W-1:0]   sync1_q;
    logic [GPIO_W-1:0]   sync2_q;
    logic [31:0]         cycle_q;
    logic [31:0]         cmp_q;
    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_set;
    logic [STATUS_W-1:0] status_clr;
    logic                ctrl_q;

    always_comb begin
        status_set              = '0;
        status_set[ST_MATCH]    = (cycle_q == cmp_q);
        status_set[ST_MISALIGN] = set_misalign;
        status_set[ST_COLLIDE]  = set_collide;
        status_clr              = '0;
        if (wr_en && offset == OFF_STATUS) status_clr = wdata[STATUS_W-1:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= '0;
            cmp_q      <= '1;
            status_q   <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            // Clear is applied before set so a simultaneous event keeps the flag
            status_q <= (status_q & ~status_clr) | status_set;
            if (wr_en) begin
                case (offset)
                    OFF_GPIO_OUT:  gpio_out_q <= wdata[GPIO_W-1:0];
                    OFF_TIMER_CMP: cmp_q      <= wdata;
                    OFF_CTRL:      ctrl_q     <= wdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_GPIO_OUT:  rdata = 32'(gpio_out_q);
            OFF_GPIO_IN:   rdata = 32'(sync2_q);
            OFF_CYCLE:     rdata = cycle_q;
            OFF_TIMER_CMP: rdata = cmp_q;
            OFF_STATUS:    rdata = 32'(status_q);
            OFF_CTRL:      rdata = {31'd0, ctrl_q};
            default: ;
        endcase
    end

    assign gpio_out = gpio_out_q;
    assign irq      = ctrl_q & status_q[ST_MATCH];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core: address decode, word RAM and read mux over RAM/MMIO.
module dmem_responder #(
    parameter int unsigned RAM_WORDS = 240,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [9:0]        DIR_DMEM,
    input  logic [31:0]       DATA_WRITE_DMEM,
    input  logic              READ,
    input  logic              WRITE,
    output logic [31:0]       DATA_READ_DMEM,
    input  logic [GPIO_W-1:0] GPIO_IN,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              IRQ
);
    import dmem_pkg::*;

    localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [8:0]  RAM_LIMIT = 9'(RAM_WORDS);

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_rdata;
    logic [31:0]       mmio_rdata;
    logic              mmio_wr;
    logic              access;
    logic [31:0]       ram [RAM_WORDS];

    assign region  = decode_region(DIR_DMEM, RAM_LIMIT);
    assign ram_idx = DIR_DMEM[RAM_AW+1:2];
    assign access  = READ | WRITE;
    assign mmio_wr = WRITE && (region == REG_MMIO);

    // RAM is deliberately not reset so contents survive RESET_N
    always_ff @(posedge CLK) begin
        if (WRITE && region == REG_RAM) ram[ram_idx] <= DATA_WRITE_DMEM;
    end

    assign ram_rdata = ram[ram_idx];

    always_comb begin
        DATA_READ_DMEM = '0;
        if (READ) begin
            case (region)
                REG_RAM:  DATA_READ_DMEM = ram_rdata;
                REG_MMIO: DATA_READ_DMEM = mmio_rdata;
                default: ;
            endcase
        end
    end

    dmem_mmio #(
        .GPIO_W(GPIO_W)
    ) u_mmio (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .wr_en        (mmio_wr),
        .offset       (DIR_DMEM[5:2]),
        .wdata        (DATA_WRITE_DMEM),
        .set_misalign (access && (DIR_DMEM[1:0] != 2'b00)),
        .set_collide  (READ && WRITE),
        .gpio_in      (GPIO_IN),
        .gpio_out     (GPIO_OUT),
        .rdata        (mmio_rdata),
        .irq          (IRQ)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes model predictions, monitor compares each cycle.
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  DIR_DMEM = '0;
    logic [31:0] DATA_WRITE_DMEM = '0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [31:0] DATA_READ_DMEM;
    logic [7:0]  GPIO_IN = '0;
    logic [7:0]  GPIO_OUT;
    logic        IRQ;

    always #5 CLK = ~CLK;

    dmem_responder #(
        .RAM_WORDS(200),
        .GPIO_W   (8)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .DIR_DMEM       (DIR_DMEM),
        .DATA_WRITE_DMEM(DATA_WRITE_DMEM),
        .READ           (READ),
        .WRITE          (WRITE),
        .DATA_READ_DMEM (DATA_READ_DMEM),
        .GPIO_IN        (GPIO_IN),
        .GPIO_OUT       (GPIO_OUT),
        .IRQ            (IRQ)
    );

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [7:0]  gout;
        logic        irq;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model state, expressed as the programmer-visible registers
    logic [31:0] m_mem [256];
    logic [7:0]  m_gout;
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    logic [2:0]  m_status;
    logic        m_ctrl;
    logic [7:0]  m_pin_hist[$];
    logic [7:0]  pins = '0;
    logic        rst_drive = 1'b0;

    function automatic logic [7:0] pins_visible();
        if (m_pin_hist.size() >= 2) return m_pin_hist[m_pin_hist.size()-2];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [9:0] a);
        int unsigned w = int'(a) / 4;
        if (a >= 10'h3C0) begin
            case (w - 240)
                0: return {24'd0, m_gout};
                1: return {24'd0, pins_visible()};
                2: return m_cycle;
                3: return m_cmp;
                4: return {29'd0, m_status};
                5: return {31'd0, m_ctrl};
                default: return 32'd0;
            endcase
        end
        if (w < 200) return m_mem[w];
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_gout = 8'h00;
        m_cycle = 32'd0;
        m_cmp = 32'hFFFF_FFFF;
        m_status = 3'b000;
        m_ctrl = 1'b0;
        m_pin_hist.delete();
    endtask

    task automatic model_step(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
        int unsigned w = int'(a) / 4;
        logic [2:0] set_b;
        logic [2:0] clr_b = 3'b000;
        set_b[0] = (m_cycle == m_cmp);
        set_b[1] = (rd || wr) && (a % 4 != 0);
        set_b[2] = rd && wr;
        if (wr) begin
            if (a >= 10'h3C0) begin
                case (w - 240)
                    0: m_gout = d[7:0];
                    3: m_cmp = d;
                    4: clr_b = d[2:0];
                    5: m_ctrl = d[0];
                    default: ;
                endcase
            end else if (w < 200) begin
                m_mem[w] = d;
            end
        end
        m_status = (m_status & ~clr_b) | set_b;
        m_cycle = m_cycle + 32'd1;
        m_pin_hist.push_back(pins);
        if (m_pin_hist.size() > 2) void'(m_pin_hist.pop_front());
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d, input string name);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET_N = rst_drive;
        if (!rst_drive) model_reset();
        READ = rd;
        WRITE = wr;
        DIR_DMEM = a;
        DATA_WRITE_DMEM = d;
        GPIO_IN = pins;
        e.name = name;
        e.rd = rd ? model_read(a) : 32'd0;
        e.gout = m_gout;
        e.irq = m_ctrl & m_status[0];
        exp_q.push_back(e);
        if (rst_drive) model_step(rd, wr, a, d);
    endtask

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32({e.name, "/rdata"}, DATA_READ_DMEM, e.rd);
                chk32({e.name, "/gpio_out"}, {24'd0, GPIO_OUT}, {24'd0, e.gout});
                chk32({e.name, "/irq"}, {31'd0, IRQ}, {31'd0, e.irq});
            end
        end
    end

    initial begin : driver
        int unsigned guard;
        logic [9:0]  a;
        logic [31:0] d;
        logic        rd;
        logic        wr;

        model_reset();
        rst_drive = 1'b0;
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "reset_status");
        cyc(1'b1, 1'b0, 10'h3CC, 32'd0, "reset_cmp");
        cyc(1'b0, 1'b0, 10'h000, 32'd0, "reset_idle");
        rst_drive = 1'b1;
        cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "cycle_first");
        cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "cycle_second");

        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, 10'(i * 4), $urandom, "ram_init");

        cyc(1'b0, 1'b1, 10'h010, 32'hDEAD_BEEF, "wr_010");
        cyc(1'b1, 1'b0, 10'h010, 32'd0, "rd_010");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "status_clean");
        cyc(1'b1, 1'b0, 10'h014, 32'd0, "rd_014");

        cyc(1'b0, 1'b1, 10'h023, 32'h1234_5678, "wr_misaligned");
        cyc(1'b1, 1'b0, 10'h020, 32'd0, "rd_020");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "status_misalign");
        cyc(1'b1, 1'b1, 10'h020, 32'hAAAA_5555, "collide");
        cyc(1'b1, 1'b0, 10'h020, 32'd0, "rd_after_collide");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "status_errs");
        cyc(1'b0, 1'b1, 10'h3D0, 32'h6, "w1c_errs");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "status_cleared");

        cyc(1'b0, 1'b1, 10'h3C0, 32'h1A5, "wr_gpio");
        cyc(1'b1, 1'b0, 10'h3C0, 32'd0, "rd_gpio");
        pins = 8'h3C;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 10'h3C4, 32'd0, "gpio_in_sync");

        cyc(1'b0, 1'b1, 10'h3D4, 32'd1, "ctrl_en");
        cyc(1'b0, 1'b1, 10'h3CC, m_cycle + 32'd5, "cmp_plus5");
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "timer_wait");
        cyc(1'b0, 1'b1, 10'h3D0, 32'd1, "irq_clear");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "irq_cleared");

        cyc(1'b0, 1'b1, 10'h3CC, m_cycle + 32'd3, "cmp_plus3");
        guard = 0;
        while (m_cycle != m_cmp && guard < 20) begin
            cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "pre_match");
            guard++;
        end
        cyc(1'b0, 1'b1, 10'h3D0, 32'd1, "clr_vs_match");
        cyc(1'b1, 1'b0, 10'h3D0, 32'd0, "set_wins");
        cyc(1'b0, 1'b1, 10'h3D0, 32'd7, "clr_all");

        cyc(1'b1, 1'b0, 10'h3F0, 32'd0, "rd_3f0");
        cyc(1'b1, 1'b0, 10'h3BC, 32'd0, "rd_3bc");
        cyc(1'b0, 1'b1, 10'h3F0, 32'h5555_AAAA, "wr_3f0");
        cyc(1'b0, 1'b1, 10'h3BC, 32'h5555_AAAA, "wr_3bc");
        cyc(1'b1, 1'b0, 10'h3F0, 32'd0, "rd_3f0_again");
        cyc(1'b1, 1'b0, 10'h3BC, 32'd0, "rd_3bc_again");

        cyc(1'b0, 1'b1, 10'h3C0, 32'hFF, "gpio_ff");
        guard = 0;
        while (m_cycle != 32'd1000 && guard < 2000) begin
            cyc(1'b1, 1'b0, 10'($urandom_range(0, 199) * 4), 32'd0, "run_to_1000");
            guard++;
        end
        cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "cycle_1000");
        rst_drive = 1'b0;
        cyc(1'b1, 1'b0, 10'h3C0, 32'd0, "mid_reset_gpio");
        cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "mid_reset_cycle");
        rst_drive = 1'b1;
        cyc(1'b1, 1'b0, 10'h3C8, 32'd0, "cycle_after_rst");
        cyc(1'b1, 1'b0, 10'h010, 32'd0, "ram_kept");
        cyc(1'b1, 1'b0, 10'h3CC, 32'd0, "cmp_after_rst");

        for (int i = 0; i < 500; i++) begin
            a = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) a = 10'h3C0 + 10'($urandom_range(0, 31));
            rd = 1'($urandom);
            wr = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (a[9:2] == 8'hF3 && d[0]) d = m_cycle + 32'($urandom_range(1, 6));
            if (a[9:2] == 8'hF4) d = d & 32'h0000_0006;
            pins = 8'($urandom);
            cyc(rd, wr, a, d, "random");
        end

        cyc(1'b0, 1'b0, 10'h000, 32'd0, "drain");
        @(posedge CLK);
        @(posedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
